// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, sync-window helpers and the registered flag bundle
// used by vga_sync_gen (optional checker enabled by SYNC_GEN_CHECK_EN).
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Sync pulse occupies [active+fp, active+fp+sync-1] inclusive.
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic line_start;
    logic frame_start;
    logic v_tc;
  } sync_flags_t;

endpackage

// File: rtl/vga_sync_gen_vert_line_counter.sv
// Vertical line counter: advances once per h_tc and wraps after V_TOTAL lines,
// mirroring the upstream horizontal pixel counter.
module vert_line_counter #(
  parameter int WIDTH   = 10,
  parameter int V_TOTAL = 525
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_h_tc,
  output logic [WIDTH-1:0] o_vcnt,
  output logic             o_last_line
);

  localparam logic [WIDTH-1:0] V_LAST = WIDTH'(V_TOTAL - 1);

  logic [WIDTH-1:0] r_vcnt;

  assign o_vcnt      = r_vcnt;
  assign o_last_line = (r_vcnt == V_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vcnt <= '0;
    end else if (i_h_tc) begin
      r_vcnt <= o_last_line ? '0 : r_vcnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/timing decode downstream of the horizontal counter; every output is registered
// once from (hcnt, vcnt). Define SYNC_GEN_CHECK_EN to build the sticky sync_err checker.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   WIDTH    = 10,
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] hcnt,
  input  logic             h_tc,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [WIDTH-1:0] pix_x,
  output logic [WIDTH-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start,
  output logic             v_tc,
  output logic             sync_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [WIDTH-1:0] H_ACT_W  = WIDTH'(H_ACTIVE);
  localparam logic [WIDTH-1:0] V_ACT_W  = WIDTH'(V_ACTIVE);
  localparam logic [WIDTH-1:0] HS_START = WIDTH'(sync_start(H_ACTIVE, H_FP));
  localparam logic [WIDTH-1:0] HS_END   = WIDTH'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [WIDTH-1:0] VS_START = WIDTH'(sync_start(V_ACTIVE, V_FP));
  localparam logic [WIDTH-1:0] VS_END   = WIDTH'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  localparam sync_flags_t FLAGS_RST = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, default: 1'b0};

  // No back-pressure: one (hcnt, h_tc) pair is consumed on every pclk edge out of reset.
  logic [WIDTH-1:0] w_vcnt;
  logic             w_last_line;
  logic             w_video_on;
  sync_flags_t      w_flags;
  sync_flags_t      r_flags;
  logic [WIDTH-1:0] r_pix_x;
  logic [WIDTH-1:0] r_pix_y;

  vert_line_counter #(
    .WIDTH   (WIDTH),
    .V_TOTAL (V_TOTAL)
  ) u_vert_line_counter (
    .i_clk       (pclk),
    .i_rst_n     (rst_n),
    .i_h_tc      (h_tc),
    .o_vcnt      (w_vcnt),
    .o_last_line (w_last_line)
  );

  // Out-of-range hcnt falls past HS_END and H_ACT_W, so it decodes as plain blanking.
  assign w_video_on = (hcnt < H_ACT_W) && (w_vcnt < V_ACT_W);

  always_comb begin
    w_flags             = FLAGS_RST;
    w_flags.hsync       = ((hcnt >= HS_START) && (hcnt <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    w_flags.vsync       = ((w_vcnt >= VS_START) && (w_vcnt <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    w_flags.video_on    = w_video_on;
    w_flags.line_start  = (hcnt == '0);
    w_flags.frame_start = (hcnt == '0) && (w_vcnt == '0);
    w_flags.v_tc        = h_tc && w_last_line;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= FLAGS_RST;
      r_pix_x <= '0;
      r_pix_y <= '0;
    end else begin
      r_flags <= w_flags;
      r_pix_x <= w_video_on ? hcnt : '0;
      r_pix_y <= w_video_on ? w_vcnt : '0;
    end
  end

  assign hsync       = r_flags.hsync;
  assign vsync       = r_flags.vsync;
  assign video_on    = r_flags.video_on;
  assign line_start  = r_flags.line_start;
  assign frame_start = r_flags.frame_start;
  assign v_tc        = r_flags.v_tc;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;

`ifdef SYNC_GEN_CHECK_EN
  localparam logic [WIDTH-1:0] H_LAST  = WIDTH'(H_TOTAL - 1);
  localparam logic [WIDTH-1:0] H_TOT_W = WIDTH'(H_TOTAL);

  logic w_timing_bad;
  logic r_sync_err;

  assign w_timing_bad = (h_tc && (hcnt != H_LAST)) ||
                        (!h_tc && (hcnt == H_LAST)) ||
                        (hcnt >= H_TOT_W);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= r_sync_err | w_timing_bad;
    end
  end

  assign sync_err = r_sync_err;
`else
  assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized bench for vga_sync_gen against a line/frame arithmetic model; honours SYNC_GEN_CHECK_EN.
module tb_vga_sync_gen;

  localparam int W  = 27;
  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 480, VF = 10, VS = 2,  VB = 33;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic       pclk  = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hcnt  = '0;
  logic       h_tc  = 1'b0;
  logic       hsync, vsync, video_on, line_start, frame_start, v_tc, sync_err;
  logic [9:0] pix_x, pix_y;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_v      = 0;
  logic       m_err    = 1'b0;
  logic [W-1:0] exp_q[$];

  always #5 pclk = ~pclk;

  vga_sync_gen dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .hcnt        (hcnt),
    .h_tc        (h_tc),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .v_tc        (v_tc),
    .sync_err    (sync_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d exp=%0d (line=%0d hcnt=%0d)", tag, $time, got, exp, m_v, hcnt);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_hsync"},  32'(hsync),       32'd1);
    check({tag, "_vsync"},  32'(vsync),       32'd1);
    check({tag, "_video"},  32'(video_on),    32'd0);
    check({tag, "_pix_x"},  32'(pix_x),       32'd0);
    check({tag, "_pix_y"},  32'(pix_y),       32'd0);
    check({tag, "_lstart"}, 32'(line_start),  32'd0);
    check({tag, "_fstart"}, 32'(frame_start), 32'd0);
    check({tag, "_v_tc"},   32'(v_tc),        32'd0);
    check({tag, "_err"},    32'(sync_err),    32'd0);
  endtask

  task automatic compare_outputs();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check("hsync",       32'(hsync),       32'(e[26]));
    check("vsync",       32'(vsync),       32'(e[25]));
    check("video_on",    32'(video_on),    32'(e[24]));
    check("pix_x",       32'(pix_x),       32'(e[23:14]));
    check("pix_y",       32'(pix_y),       32'(e[13:4]));
    check("line_start",  32'(line_start),  32'(e[3]));
    check("frame_start", 32'(frame_start), 32'(e[2]));
    check("v_tc",        32'(v_tc),        32'(e[1]));
    check("sync_err",    32'(sync_err),    32'(e[0]));
  endtask

  // Present one input pair, predict its outputs from the timing rules, check after the edge.
  task automatic drive(input int h, input logic t);
    logic       e_hs, e_vs, e_vo;
    logic [9:0] e_px, e_py;
    @(negedge pclk);
    hcnt = 10'(h);
    h_tc = t;
    e_vo = (h < HA) && (m_v < VA);
    e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
    e_vs = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
    e_px = e_vo ? 10'(h)   : 10'd0;
    e_py = e_vo ? 10'(m_v) : 10'd0;
`ifdef SYNC_GEN_CHECK_EN
    if ((t && h != HT - 1) || (!t && h == HT - 1) || (h >= HT)) m_err = 1'b1;
`endif
    exp_q.push_back({e_hs, e_vs, e_vo, e_px, e_py, 1'(h == 0), 1'(h == 0 && m_v == 0),
                     1'(t && m_v == VT - 1), m_err});
    if (t) m_v = (m_v + 1) % VT;
    @(posedge pclk);
    #1;
    compare_outputs();
  endtask

  // A short line is a lone terminal pixel, which keeps whole frames cheap to traverse.
  task automatic run_line(input bit full, input bit glitch);
    int gpos;
    gpos = $urandom_range(0, HT - 2);
    if (!full) begin
      drive(HT - 1, 1'b1);
    end else begin
      for (int h = 0; h < HT; h++) begin
        drive(h, 1'(h == HT - 1));
        if (glitch && h == gpos) drive(int'($urandom_range(HT, 1023)), 1'b0);
      end
    end
  endtask

  function automatic bit is_key(input int v);
    return (v == 0) || (v == 1) || (v == VA - 1) || (v == VA) || (v == VA + VF - 1) ||
           (v == VA + VF) || (v == VA + VF + 1) || (v == VA + VF + VS) ||
           (v == VT - 2) || (v == VT - 1);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      hcnt = 10'($urandom_range(0, 1023));
      h_tc = 1'($urandom_range(0, 1));
      @(posedge pclk);
      #1;
      check_reset("in_rst");
    end
    hcnt = '0;
    h_tc = 1'b0;
    #1 rst_n = 1'b1;

    for (int n = 0; n < VT; n++) run_line(is_key(m_v) || ($urandom_range(0, 63) == 0), 1'b0);

    while (m_v != 200) run_line(is_key(m_v) || ($urandom_range(0, 63) == 0), 1'b0);
    for (int h = 0; h < 300; h++) drive(h, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset("async");
    m_v   = 0;
    m_err = 1'b0;
    exp_q.delete();
    hcnt  = '0;
    h_tc  = 1'b0;
    repeat (2) begin
      @(posedge pclk);
      #1;
      check_reset("held");
    end
    #1 rst_n = 1'b1;

    for (int n = 0; n < VT; n++) begin
      if (m_v == 100) begin
        run_line(1'b1, 1'b1);
      end else if (m_v == 300) begin
        for (int h = 0; h <= 400; h++) drive(h, 1'(h == 400));
        repeat (3) drive(HT - 1, 1'b1);
      end else begin
        run_line(is_key(m_v) || ($urandom_range(0, 63) == 0),
                 (n > 300) && ($urandom_range(0, 15) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
